als_slave: RTL

ALS_SLAVE -- requirements
Module: als_slave

---
 rtl/als_slave.sv | 138 +++++++++++++
 1 files changed

// File: rtl/als_slave.sv
// SPI-style read slave: streams a framed sample word out on sdo, MSB first,
// shifting on sck falling edges seen through clk-domain synchronizers.
module als_slave #(
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned LEAD_ZEROS = 3,
  parameter int unsigned FRAME_BITS = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cs,
  input  logic                 sck,
  output logic                 sdo,
  input  logic [DATA_BITS-1:0] sample,
  input  logic                 sample_valid,
  output logic                 sample_ready,
  output logic                 busy,
  output logic                 frame_done,
  output logic                 frame_abort
);

  localparam int unsigned TRAIL_BITS = FRAME_BITS - LEAD_ZEROS - DATA_BITS;
  localparam int unsigned CNT_W      = $clog2(FRAME_BITS);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_BITS - 1);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } state_t;

  logic                  r_cs_meta;
  logic                  r_cs_sync;
  logic                  r_cs_prev;
  logic                  r_sck_meta;
  logic                  r_sck_sync;
  logic                  r_sck_prev;
  state_t                r_state;
  logic [DATA_BITS-1:0]  r_hold;
  logic [FRAME_BITS-1:0] r_shift;
  logic [CNT_W-1:0]      r_cnt;
  logic                  r_done;
  logic                  r_abort;
  logic                  r_ready;

  logic                  w_cs_fall;
  logic                  w_cs_rise;
  logic                  w_sck_fall;
  logic [FRAME_BITS-1:0] w_frame;
  state_t                w_state_nxt;
  logic [FRAME_BITS-1:0] w_shift_nxt;
  logic [CNT_W-1:0]      w_cnt_nxt;
  logic                  w_done_nxt;
  logic                  w_abort_nxt;

  // Edge detection on the synchronized pins; sck rising edges are never used.
  assign w_cs_fall  =  r_cs_prev  & ~r_cs_sync;
  assign w_cs_rise  = ~r_cs_prev  &  r_cs_sync;
  assign w_sck_fall =  r_sck_prev & ~r_sck_sync;

  assign w_frame = FRAME_BITS'(r_hold) << TRAIL_BITS;

  // Next-state and datapath decode
  always_comb begin
    w_state_nxt = r_state;
    w_shift_nxt = r_shift;
    w_cnt_nxt   = r_cnt;
    w_done_nxt  = 1'b0;
    w_abort_nxt = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_cs_fall) begin
          w_state_nxt = S_SHIFT;
          w_shift_nxt = w_frame;
          w_cnt_nxt   = '0;
        end
      end
      S_SHIFT: begin
        if (w_cs_rise) begin
          w_state_nxt = S_IDLE;
          w_shift_nxt = '0;
          if (r_cnt == LAST_CNT) begin
            w_done_nxt = 1'b1;
          end else begin
            w_abort_nxt = 1'b1;
          end
        end else if (w_sck_fall) begin
          w_shift_nxt = r_shift << 1;
          if (r_cnt != LAST_CNT) begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State, synchronizers and hold register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cs_meta  <= 1'b1;
      r_cs_sync  <= 1'b1;
      r_cs_prev  <= 1'b1;
      r_sck_meta <= 1'b1;
      r_sck_sync <= 1'b1;
      r_sck_prev <= 1'b1;
      r_state    <= S_IDLE;
      r_hold     <= '0;
      r_shift    <= '0;
      r_cnt      <= '0;
      r_done     <= 1'b0;
      r_abort    <= 1'b0;
      r_ready    <= 1'b1;
    end else begin
      r_cs_meta  <= cs;
      r_cs_sync  <= r_cs_meta;
      r_cs_prev  <= r_cs_sync;
      r_sck_meta <= sck;
      r_sck_sync <= r_sck_meta;
      r_sck_prev <= r_sck_sync;
      r_state    <= w_state_nxt;
      r_shift    <= w_shift_nxt;
      r_cnt      <= w_cnt_nxt;
      r_done     <= w_done_nxt;
      r_abort    <= w_abort_nxt;
      r_ready    <= 1'b1;
      // Frame load above reads the old hold, so a coincident transfer lands in the next frame.
      if (sample_valid && r_ready) begin
        r_hold <= sample;
      end
    end
  end

  assign sdo          = r_shift[FRAME_BITS-1];
  assign busy         = (r_state == S_SHIFT);
  assign frame_done   = r_done;
  assign frame_abort  = r_abort;
  assign sample_ready = r_ready;

endmodule
